// File: rtl/squarer_pkg.sv
// Shared definitions for the 8-bit squarer reduction stage.
// Holds the operand and bus widths, the partial-product index helper and the
// accumulator FSM state type.
package squarer_pkg;

  localparam int unsigned N_OP  = 8;
  localparam int unsigned PP_W  = N_OP * (N_OP + 1) / 2;
  localparam int unsigned OUT_W = 2 * N_OP;
  localparam int unsigned IDX_W = $clog2(PP_W);
  localparam int unsigned ROW_W = $clog2(N_OP);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  // Bit position of pp_ij (i >= j) in the packed triangular bus.
  function automatic int unsigned pp_idx(input int unsigned i, input int unsigned j);
    return i * (i + 1) / 2 + j;
  endfunction

endpackage

// File: rtl/squarer_row_sel_8bit.sv
// Row selector for the squarer accumulator.
// Combinationally weights one row of the captured triangular partial-product
// set into an OUT_W-bit value:
//   row_value(i) = pp_ii << 2i + sum_{j<i} pp_ij << (i+j+1)
// Ports:
//   pp        - captured packed partial products (PP_W bits)
//   row       - row index 0..7
//   row_value - weighted row, OUT_W bits
module squarer_row_sel_8bit
  import squarer_pkg::*;
(
  input  logic [PP_W-1:0]  pp,
  input  logic [ROW_W-1:0] row,
  output logic [OUT_W-1:0] row_value
);

  always_comb begin
    row_value = '0;
    for (int unsigned i = 0; i < N_OP; i++) begin
      if (row == ROW_W'(i)) begin
        // Diagonal term carries weight 2^(2i); cross terms are doubled,
        // hence the extra +1 in their shift.
        row_value = OUT_W'(pp[IDX_W'(pp_idx(i, i))]) << (2 * i);
        for (int unsigned j = 0; j < i; j++) begin
          row_value = row_value + (OUT_W'(pp[IDX_W'(pp_idx(i, j))]) << (i + j + 1));
        end
      end
    end
  end

endmodule

// File: rtl/squarer_accum_8bit.sv
// Sequential reduction stage of the 8-bit squarer.
// Captures one set of 36 partial products, adds one weighted row per cycle for
// eight cycles, then presents the 16-bit square on a valid/ready handshake.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready - input handshake; pp_bus captured when both high
//   pp_bus              - packed partial products, pp_ij at i*(i+1)/2 + j
//   out_valid/out_ready - output handshake for square
//   square              - accumulated result (registered)
//   busy                - high while accumulating or holding a result
module squarer_accum_8bit
  import squarer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  pp_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] square,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [PP_W-1:0]    pp_q, pp_d;
  logic [OUT_W-1:0]   row_value;
  logic [OUT_W:0]     sum;

  squarer_row_sel_8bit u_row_sel (
    .pp        (pp_q),
    .row       (row_q),
    .row_value (row_value)
  );

  // One extra bit so a carry out of the accumulator is observable.
  assign sum = {1'b0, acc_q} + {1'b0, row_value};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StAccum;
      StAccum: if (row_q == ROW_W'(N_OP - 1)) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    pp_d  = pp_q;
    acc_d = acc_q;
    row_d = row_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pp_d  = pp_bus;
          acc_d = '0;
          row_d = '0;
        end
      end
      StAccum: begin
        acc_d = sum[OUT_W-1:0];
        row_d = row_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_q  <= '0;
      acc_q <= '0;
      row_q <= '0;
    end else begin
      pp_q  <= pp_d;
      acc_q <= acc_d;
      row_q <= row_d;
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StAccum: busy = 1'b1;
      StDone: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign square = acc_q;

  // Real operands never exceed 255*255, so a carry here means a bad design.
  a_no_carry: assert property (@(posedge clk) disable iff (rst)
    (state_q == StAccum) |-> !sum[OUT_W]);

endmodule

// File: tb/tb_squarer_accum_8bit.sv
module tb_squarer_accum_8bit;
  import squarer_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [PP_W-1:0]  pp_bus = '0;
  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic [OUT_W-1:0] square;

  int n_checks = 0;
  int n_pass = 0;
  logic [OUT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  squarer_accum_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_bus    (pp_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .square    (square),
    .busy      (busy)
  );

  // Reference partial-product generator: pp_ij = a_i & a_j, packed row by row.
  function automatic logic [PP_W-1:0] make_pp(input logic [7:0] a);
    logic [PP_W-1:0] pp;
    int k;
    pp = '0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j <= i; j++) begin
        pp[k[5:0]] = a[i[2:0]] & a[j[2:0]];
        k++;
      end
    end
    return pp;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with in_valid
  // still high. Pushes the expected square on acceptance.
  task automatic drive_input(input logic [7:0] a);
    int   waited;
    logic acc;
    waited = 0;
    pp_bus = make_pp(a);
    in_valid = 1'b1;
    acc = 1'b0;
    while (!acc) begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          n_checks++;
          $display("FAIL accept_timeout: a=%0d not accepted after %0d cycles", a, waited);
          in_valid = 1'b0;
          return;
        end
      end
    end
    exp_q.push_back(16'(a) * 16'(a));
  endtask

  // Counts rising edges from the current negedge until out_valid is seen.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (square !== 16'h0000) $display("FAIL reset_square: got %h want 0000", square);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [7:0]       vals[4];
    logic [OUT_W-1:0] e;
    int               cyc;
    vals = '{8'd0, 8'd255, 8'd13, 8'd128};
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      drive_input(vals[v]);
      in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL corner_busy a=%0d: busy=%b in_ready=%b want 1/0", vals[v], busy, in_ready);
      else n_pass++;
      wait_valid(cyc);
      n_checks++;
      if (cyc !== 8) $display("FAIL corner_latency a=%0d: got %0d want 8", vals[v], cyc);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL corner_square a=%0d: scoreboard empty", vals[v]);
      else begin
        e = exp_q.pop_front();
        if (square !== e) $display("FAIL corner_square a=%0d: got %h want %h", vals[v], square, e);
        else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL corner_release a=%0d: out_valid=%b in_ready=%b want 0/1",
                 vals[v], out_valid, in_ready);
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    int got;
    got = 0;
    fork
      begin
        for (int a = 0; a < 256; a++) drive_input(a[7:0]);
        in_valid = 1'b0;
      end
      begin
        logic [OUT_W-1:0] e;
        int cyc;
        cyc = 0;
        while (got < 256 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL sweep_square #%0d: scoreboard empty", got);
            else begin
              e = exp_q.pop_front();
              if (square !== e) $display("FAIL sweep_square #%0d: got %h want %h", got, square, e);
              else n_pass++;
            end
            got++;
          end
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (got !== 256) $display("FAIL sweep_count: got %0d results want 256", got);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] e;
    int cyc;
    out_ready = 1'b0;
    drive_input(8'd200);
    in_valid = 1'b0;
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 8) $display("FAIL bp_latency: got %0d want 8", cyc);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      pp_bus = PP_W'({$urandom(), $urandom()});
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || square !== 16'h9C40 || in_ready !== 1'b0)
        $display("FAIL bp_hold k=%0d: out_valid=%b square=%h in_ready=%b want 1/9c40/0",
                 k, out_valid, square, in_ready);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL bp_square: scoreboard empty");
    else begin
      e = exp_q.pop_front();
      if (square !== e) $display("FAIL bp_square: got %h want %h", square, e);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_no_capture: out_valid=%b busy=%b want 0/0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [OUT_W-1:0] e;
    logic saw;
    int cyc;
    out_ready = 1'b1;
    drive_input(8'd99);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || square !== 16'h0000)
      $display("FAIL rst_mid: out_valid=%b in_ready=%b busy=%b square=%h want 0/1/0/0000",
               out_valid, in_ready, busy, square);
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL rst_mid_no_valid: got %b want 0", saw);
    else n_pass++;
    drive_input(8'd3);
    in_valid = 1'b0;
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 8) $display("FAIL rst_mid_next_latency: got %0d want 8", cyc);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL rst_mid_next_square: scoreboard empty");
    else begin
      e = exp_q.pop_front();
      if (square !== e) $display("FAIL rst_mid_next_square: got %h want %h", square, e);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] e;
    int cyc;
    out_ready = 1'b0;
    drive_input(8'd5);
    in_valid = 1'b0;
    wait_valid(cyc);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_in_ready_done: got %b want 0", in_ready);
    else n_pass++;
    out_ready = 1'b1;
    in_valid = 1'b1;
    pp_bus = make_pp(8'd7);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL b2b_first_square: scoreboard empty");
    else begin
      e = exp_q.pop_front();
      if (square !== e) $display("FAIL b2b_first_square: got %h want %h", square, e);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b busy=%b want 0/1/0",
               out_valid, in_ready, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL b2b_accept: busy=%b in_ready=%b want 1/0", busy, in_ready);
    else n_pass++;
    exp_q.push_back(16'd49);
    in_valid = 1'b0;
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 8) $display("FAIL b2b_latency: got %0d want 8", cyc);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL b2b_second_square: scoreboard empty");
    else begin
      e = exp_q.pop_front();
      if (square !== e) $display("FAIL b2b_second_square: got %h want %h", square, e);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_corners();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/squarer_accum_8bit.md
Name: squarer_accum_8bit

Overview:
- Sequential reduction stage directly downstream of the 8-bit partial-product generator.
- Accepts one packed set of 36 partial products per transaction and accumulates one row per cycle into the 16-bit square.
- Presents the result on a valid/ready output handshake.
- Sits between the partial-product stage and the squarer top-level result register.

Parameters:
- N, 8, operand width; only 8 is supported.
- PP_W, N*(N+1)/2 = 36, packed partial-product bus width; derived, not overridable.
- OUT_W, 2*N = 16, result width; derived.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  pp_bus holds a valid partial-product set
- in_ready  output  1  block can accept a set
- pp_bus  input  PP_W  packed partial products; pp_ij (i>=j) at bit index i*(i+1)/2 + j (pp00=bit0, pp10=bit1, pp11=bit2, pp20=bit3, ..., pp77=bit35)
- out_valid  output  1  square is valid
- out_ready  input  1  consumer accepts square
- square  output  OUT_W  accumulated a*a
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, active-high) values: state=IDLE, in_ready=1, out_valid=0, square=0, busy=0, row counter=0, pp capture register=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: capture pp_bus, clear the accumulator, set row=0, go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each cycle adds row_value(row) to the accumulator and increments row.
  - row_value(i) = pp_ii<<(2i) + sum over j<i of pp_ij<<(i+j+1), truncated to OUT_W.
  - After row 7 has been added (8 ACCUM cycles), go to DONE.
- DONE:
  - out_valid=1; square = accumulator, held stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: out_valid drops next cycle, go to IDLE.
- Latency: handshake accepted at edge E0; out_valid asserts after edge E0+8.
- Throughput: one result per 10 cycles minimum (1 capture + 8 accumulate + 1 handshake). No input overlap.
- Arithmetic:
  - Unsigned throughout.
  - Maximum sum is 255*255 = 65025, so no overflow of the 16-bit accumulator.
  - Intermediate adds are 16 bits wide; any carry out of bit 15 is an error, flagged by an assertion in simulation.
- Boundary conditions:
  - in_valid while not in IDLE is ignored; the upstream must hold its data (standard valid/ready).
  - out_ready high before DONE has no effect.
  - in_valid and out_ready asserted in the same cycle in DONE: only the output handshake completes. Input is accepted on the next IDLE cycle, never in the same cycle as DONE.
  - pp_bus may change after capture without affecting the result.
  - rst asserted mid-ACCUM or in DONE: immediate return to reset values; the partial result is discarded and out_valid never pulses.
  - pp_bus inconsistent with any real operand (e.g. pp10=1 with pp00=0) is still summed literally; no consistency checking.
- square and out_valid are registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package squarer_pkg:
  - N_OP=8, PP_W=36, OUT_W=16.
  - Function pp_idx(i,j) = i*(i+1)/2 + j.
  - FSM state enum {IDLE, ACCUM, DONE}.
- One natural sub-module: squarer_row_sel_8bit. Combinational; takes the captured pp register and row index (3 bits) and returns the OUT_W-bit row_value.
- FSM, counter, accumulator and handshake stay in the top module.

Test Plan:
- Reset then a=0 (all pp=0), in_valid one cycle, out_ready=1 -> out_valid after 8 cycles post-accept, square=0x0000, in_ready back to 1 the cycle after the output handshake.
- pp_bus built from a=255 (all 36 bits=1) -> square=0xFEo1 (65025); a=13 -> 169 (0x00A9); a=128 (only pp77=1) -> 0x4000.
- Exhaustive sweep a=0..255 through a reference partial-product model, back-to-back in_valid, random out_ready -> every square=a*a, in order, no drops or duplicates.
- Backpressure: a=200, hold out_ready=0 for 5 cycles in DONE, toggle pp_bus and in_valid meanwhile -> square stays 40000 (0x9C40), in_ready=0, no new capture.
- Reset mid-operation: assert rst asynchronously at ACCUM row 4 for a=99 -> outputs go to reset values immediately, no out_valid; the next transaction a=3 yields 9.
- Simultaneous events: in DONE, drive out_ready=1 and in_valid=1 with a=7 -> current result consumed; a=7 accepted on the following cycle; result 49.
